// File: rtl/cmult_pipe.sv
// -----------------------------------------------------------------------------
// cmult_pipe
//   Three-stage pipelined complex multiplier, A*B or A*conj(B), between the
//   butterfly output and the twiddle ROM path. Fixed-point in and out. Each
//   sample selects round half-up or truncate. Both parts of the result are
//   saturated to the output format, and saturated samples are counted.
//
//   Ports
//     i_clk, i_rst            clock (rising edge), synchronous active-high reset
//     i_valid / o_ready       input handshake; a sample is taken when both are high
//     i_real_A, i_imag_A      A = x + jy
//     i_real_B, i_imag_B      B = u + jv
//     i_conj                  1: multiply by conj(B); captured with the sample
//     i_round                 1: round half-up, 0: truncate toward -inf; captured
//     o_valid / i_ready       output handshake
//     o_real, o_imag          saturated product
//     o_sat                   this output sample clipped in real or imag
//     i_sat_clr               clear the saturation counter (wins over increment)
//     o_sat_cnt               count of saturated output handshakes, sticky at max
// -----------------------------------------------------------------------------
module cmult_pipe #(
    parameter int NB_IN     = 17,
    parameter int NBF_IN    = 7,
    parameter int NB_OUT    = 17,
    parameter int NBF_OUT   = 7,
    parameter int NB_SATCNT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_IN-1:0]     i_real_A,
    input  logic [NB_IN-1:0]     i_imag_A,
    input  logic [NB_IN-1:0]     i_real_B,
    input  logic [NB_IN-1:0]     i_imag_B,
    input  logic                 i_conj,
    input  logic                 i_round,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NB_OUT-1:0]    o_real,
    output logic [NB_OUT-1:0]    o_imag,
    output logic                 o_sat,
    input  logic                 i_sat_clr,
    output logic [NB_SATCNT-1:0] o_sat_cnt
);

    localparam int NB_PROD = 2 * NB_IN;
    localparam int NB_SUM  = 2 * NB_IN + 1;
    localparam int NB_RND  = NB_SUM + 1;
    localparam int D       = 2 * NBF_IN - NBF_OUT;
    localparam int RND_POS = (D > 0) ? D - 1 : 0;

    // Half-LSB of the output grid; zero when no bits are dropped so rounding is a no-op.
    localparam logic signed [NB_RND-1:0] RND_ONE =
        (D > 0) ? (NB_RND'(1) << RND_POS) : '0;
    localparam logic signed [NB_RND-1:0] SAT_MAX =
        {{(NB_RND-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
    localparam logic signed [NB_RND-1:0] SAT_MIN =
        {{(NB_RND-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};
    localparam logic [NB_SATCNT-1:0] CNT_MAX = '1;

    // Stage 1: captured operands and mode bits
    logic                     r_s1_valid, r_s1_conj, r_s1_round;
    logic signed [NB_IN-1:0]  r_s1_x, r_s1_y, r_s1_u, r_s1_v;
    // Stage 2: partial products
    logic                     r_s2_valid, r_s2_conj, r_s2_round;
    logic signed [NB_PROD-1:0] r_s2_xu, r_s2_yv, r_s2_xv, r_s2_yu;
    // Stage 3: output register
    logic                     r_out_valid, r_sat;
    logic [NB_OUT-1:0]        r_real, r_imag;
    logic [NB_SATCNT-1:0]     r_sat_cnt;

    logic                      w_en;
    logic signed [NB_PROD-1:0] w_xu, w_yv, w_xv, w_yu;
    logic signed [NB_SUM-1:0]  w_xu_e, w_yv_e, w_xv_e, w_yu_e;
    logic signed [NB_SUM-1:0]  w_re_sum, w_im_sum;
    logic [NB_OUT:0]           w_re_q, w_im_q;

    // Stall-all pipeline: everything advances only when the output slot frees up.
    assign w_en    = !r_out_valid || i_ready;
    assign o_ready = w_en;

    // Operands widened before multiplying so the full product is kept,
    // including (-2^(NB_IN-1))^2.
    assign w_xu = NB_PROD'(r_s1_x) * NB_PROD'(r_s1_u);
    assign w_yv = NB_PROD'(r_s1_y) * NB_PROD'(r_s1_v);
    assign w_xv = NB_PROD'(r_s1_x) * NB_PROD'(r_s1_v);
    assign w_yu = NB_PROD'(r_s1_y) * NB_PROD'(r_s1_u);

    // One guard bit so sums and differences of products never wrap.
    assign w_xu_e = {r_s2_xu[NB_PROD-1], r_s2_xu};
    assign w_yv_e = {r_s2_yv[NB_PROD-1], r_s2_yv};
    assign w_xv_e = {r_s2_xv[NB_PROD-1], r_s2_xv};
    assign w_yu_e = {r_s2_yu[NB_PROD-1], r_s2_yu};

    // Returns {clipped, value}: optional half-LSB add, arithmetic shift, clamp.
    function automatic logic [NB_OUT:0] scale_sat(input logic signed [NB_SUM-1:0] sum,
                                                  input logic                     rnd);
        logic signed [NB_RND-1:0] ext;
        logic signed [NB_RND-1:0] shifted;
        ext = {sum[NB_SUM-1], sum};
        if (rnd) ext = ext + RND_ONE;
        shifted = ext >>> D;
        if (shifted > SAT_MAX)      return {1'b1, SAT_MAX[NB_OUT-1:0]};
        else if (shifted < SAT_MIN) return {1'b1, SAT_MIN[NB_OUT-1:0]};
        else                        return {1'b0, shifted[NB_OUT-1:0]};
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_re_sum = '0;
        w_im_sum = '0;
        if (r_s2_conj) begin
            w_re_sum = w_xu_e + w_yv_e;
            w_im_sum = w_yu_e - w_xv_e;
        end else begin
            w_re_sum = w_xu_e - w_yv_e;
            w_im_sum = w_xv_e + w_yu_e;
        end
    end

    assign w_re_q = scale_sat(w_re_sum, r_s2_round);
    assign w_im_q = scale_sat(w_im_sum, r_s2_round);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples the previous stage's value from before this edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_conj   <= 1'b0;
            r_s1_round  <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_u      <= '0;
            r_s1_v      <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_conj   <= 1'b0;
            r_s2_round  <= 1'b0;
            r_s2_xu     <= '0;
            r_s2_yv     <= '0;
            r_s2_xv     <= '0;
            r_s2_yu     <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_real      <= '0;
            r_imag      <= '0;
        end else if (w_en) begin
            r_s1_valid  <= i_valid;
            r_s1_conj   <= i_conj;
            r_s1_round  <= i_round;
            r_s1_x      <= i_real_A;
            r_s1_y      <= i_imag_A;
            r_s1_u      <= i_real_B;
            r_s1_v      <= i_imag_B;
            r_s2_valid  <= r_s1_valid;
            r_s2_conj   <= r_s1_conj;
            r_s2_round  <= r_s1_round;
            r_s2_xu     <= w_xu;
            r_s2_yv     <= w_yv;
            r_s2_xv     <= w_xv;
            r_s2_yu     <= w_yu;
            r_out_valid <= r_s2_valid;
            r_sat       <= r_s2_valid && (w_re_q[NB_OUT] || w_im_q[NB_OUT]);
            r_real      <= w_re_q[NB_OUT-1:0];
            r_imag      <= w_im_q[NB_OUT-1:0];
        end
    end

    // Counts saturated samples actually handed downstream; clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && i_ready && r_sat && (r_sat_cnt != CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign o_valid   = r_out_valid;
    assign o_real    = r_real;
    assign o_imag    = r_imag;
    assign o_sat     = r_sat;
    assign o_sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_cmult_pipe.sv
// -----------------------------------------------------------------------------
// tb_cmult_pipe
//   Directed and randomised bench for cmult_pipe at the default parameters.
//   Expected products are computed by a wide-integer model when a sample is
//   accepted, queued, and compared as each output handshake occurs.
// -----------------------------------------------------------------------------
module tb_cmult_pipe;

    typedef struct {
        logic signed [16:0] re;
        logic signed [16:0] im;
        logic               sat;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [16:0] i_real_A = '0, i_imag_A = '0, i_real_B = '0, i_imag_B = '0;
    logic        i_conj = 1'b0, i_round = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [16:0] o_real, o_imag;
    logic        o_sat;
    logic        i_sat_clr = 1'b0;
    logic [7:0]  o_sat_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    cmult_pipe dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_real_A  (i_real_A),
        .i_imag_A  (i_imag_A),
        .i_real_B  (i_real_B),
        .i_imag_B  (i_imag_B),
        .i_conj    (i_conj),
        .i_round   (i_round),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_real    (o_real),
        .o_imag    (o_imag),
        .o_sat     (o_sat),
        .i_sat_clr (i_sat_clr),
        .o_sat_cnt (o_sat_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [16:0] x, input logic signed [16:0] y,
                                   input logic signed [16:0] u, input logic signed [16:0] v,
                                   input bit cj, input bit rd);
        exp_t   m;
        longint xu, yv, xv, yu, re, im;
        xu = longint'(x) * longint'(u);
        yv = longint'(y) * longint'(v);
        xv = longint'(x) * longint'(v);
        yu = longint'(y) * longint'(u);
        re = cj ? xu + yv : xu - yv;
        im = cj ? yu - xv : xv + yu;
        if (rd) begin
            re = re + 64;
            im = im + 64;
        end
        re = re >>> 7;
        im = im >>> 7;
        m.sat = 1'b0;
        if (re > 65535)  begin re = 65535;  m.sat = 1'b1; end
        if (re < -65536) begin re = -65536; m.sat = 1'b1; end
        if (im > 65535)  begin im = 65535;  m.sat = 1'b1; end
        if (im < -65536) begin im = -65536; m.sat = 1'b1; end
        m.re = 17'(re);
        m.im = 17'(im);
        return m;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic signed [16:0] x, input logic signed [16:0] y,
                        input logic signed [16:0] u, input logic signed [16:0] v,
                        input bit cj, input bit rd);
        int waited = 0;
        i_real_A = x; i_imag_A = y; i_real_B = u; i_imag_B = v;
        i_conj = cj; i_round = rd; i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && waited < 1000) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready) check("send_ready_timeout", o_ready, 1);
        @(posedge i_clk);
        sb.push_back(model(x, y, u, v, cj, rd));
        #1 i_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 2000) begin
            @(negedge i_clk);
            waited++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard: compare on the cycle an output handshake is about to happen.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", o_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_real", $signed(o_real), e.re);
                check("out_imag", $signed(o_imag), e.im);
                check("out_sat", o_sat, e.sat);
            end
        end
    end

    bit done_rand;
    logic [16:0] cap_re, cap_im;

    initial begin
        // Reset state
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_ready", o_ready, 1);
        check("rst_o_real", o_real, 0);
        check("rst_sat_cnt", o_sat_cnt, 0);
        @(posedge i_clk);
        #1;

        // 1: basic product with latency check (valid visible in cycle t+3)
        send(128, 0, 0, 128, 1'b0, 1'b0);
        @(negedge i_clk); check("lat_t1", o_valid, 0);
        @(negedge i_clk); check("lat_t2", o_valid, 0);
        @(negedge i_clk); check("lat_t3", o_valid, 1);
        drain();

        // 2: conjugate vs normal
        send(128, 128, 128, 128, 1'b1, 1'b0);
        send(128, 128, 128, 128, 1'b0, 1'b0);
        // 3: rounding vs truncation, positive and negative
        send(1, 0, 64, 0, 1'b0, 1'b0);
        send(1, 0, 64, 0, 1'b0, 1'b1);
        send(-1, 0, 64, 0, 1'b0, 1'b0);
        send(-1, 0, 64, 0, 1'b0, 1'b1);
        drain();
        check("no_sat_yet", o_sat_cnt, 0);

        // 4: saturation at both rails, including the most negative squared
        send(65535, 0, 65535, 0, 1'b0, 1'b0);
        drain();
        check("sat_cnt_one", o_sat_cnt, 1);
        send(-65536, 0, 65535, 0, 1'b0, 1'b0);
        send(-65536, 0, -65536, 0, 1'b0, 1'b0);
        drain();
        check("sat_cnt_three", o_sat_cnt, 3);
        for (int i = 0; i < 300; i++) send(65535, 0, 65535, 0, 1'b0, 1'b1);
        drain();
        check("sat_cnt_sticky", o_sat_cnt, 255);
        // Clear coinciding with a saturated handshake
        send(-65536, -65536, 65535, 0, 1'b1, 1'b0);
        begin
            int waited = 0;
            @(negedge i_clk);
            while (!o_valid && waited < 20) begin
                @(negedge i_clk);
                waited++;
            end
            check("clr_out_valid", o_valid, 1);
            i_sat_clr = 1'b1;
            @(posedge i_clk);
            #1 i_sat_clr = 1'b0;
            check("sat_clr_priority", o_sat_cnt, 0);
        end
        drain();

        // 5: backpressure on 6 back-to-back samples, i_ready low cycles 2..7
        fork
            for (int i = 0; i < 6; i++) send(17'(100 * i + 3), 17'(-7 * i), 17'(50 + i), 17'(i - 20), i[0], i[1]);
            begin
                repeat (2) @(posedge i_clk);
                #1 i_ready = 1'b0;
                repeat (4) @(negedge i_clk);
                cap_re = o_real;
                cap_im = o_imag;
                @(negedge i_clk);
                check("stall_o_valid", o_valid, 1);
                check("stall_o_ready", o_ready, 0);
                check("stall_real_hold", o_real, cap_re);
                check("stall_imag_hold", o_imag, cap_im);
                @(posedge i_clk);
                @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();

        // Random valid/ready against the model
        done_rand = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge i_clk);
                        #1;
                    end
                    send(17'($urandom), 17'($urandom), 17'($urandom), 17'($urandom),
                         1'($urandom), 1'($urandom));
                end
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    @(posedge i_clk);
                    #1 i_ready = 1'($urandom_range(0, 1));
                end
                i_ready = 1'b1;
            end
        join
        drain();

        // 6: reset with samples in flight
        send(300, 5, 7, 9, 1'b0, 1'b0);
        send(65535, 0, 65535, 0, 1'b0, 1'b0);
        send(-12, 40, 3, -3, 1'b1, 1'b1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        sb.delete();
        check("midrst_o_valid", o_valid, 0);
        check("midrst_o_real", o_real, 0);
        check("midrst_o_imag", o_imag, 0);
        check("midrst_sat_cnt", o_sat_cnt, 0);
        check("midrst_o_ready", o_ready, 1);
        repeat (8) @(negedge i_clk);
        check("midrst_no_stale", o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
